// File: rtl/gesture_beep_ctrl.sv
// Turns one-cycle PAJ7620 gesture reports into a held beeper event code followed
// by a cooldown gap, and counts reports that are discarded.
module gesture_beep_ctrl #(
  parameter int unsigned CLK_FREQ = 50_000_000,
  parameter int unsigned HOLD_CYC = 10_000_000,
  parameter int unsigned COOL_CYC = 5_000_000
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic [8:0] gesture_data,
  input  logic       gesture_vld,
  output logic [2:0] flag_beep,
  output logic       busy,
  output logic       reject,
  output logic [7:0] reject_cnt
);

  localparam int unsigned CNT_W  = 24;
  localparam int unsigned CODE_W = 3;
  localparam int unsigned RCNT_W = 8;

  // CLK_FREQ only documents the timing; a zero frequency is meaningless, so it
  // falls back to the shortest legal limit.
  localparam logic [CNT_W-1:0] HOLD_LIM = (CLK_FREQ != 0) ? CNT_W'(HOLD_CYC) : CNT_W'(1);
  localparam logic [CNT_W-1:0] COOL_LIM = (CLK_FREQ != 0) ? CNT_W'(COOL_CYC) : CNT_W'(1);
  localparam logic [RCNT_W-1:0] RCNT_MAX = '1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    COOL = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [CNT_W-1:0]    r_cnt;
  logic [CNT_W-1:0]    w_cnt_nxt;
  logic [CODE_W-1:0]   w_code;
  logic                w_accept;
  logic [CODE_W-1:0]   w_flag_nxt;
  logic                w_busy_nxt;
  logic                w_reject_nxt;
  logic [RCNT_W-1:0]   w_rcnt_nxt;

  // One-hot gesture word to event code; zero marks an invalid report.
  always_comb begin
    w_code = '0;
    case (gesture_data)
      9'h001:                 w_code = 3'd1;
      9'h002:                 w_code = 3'd2;
      9'h004:                 w_code = 3'd3;
      9'h008:                 w_code = 3'd4;
      9'h010:                 w_code = 3'd5;
      9'h020:                 w_code = 3'd6;
      9'h040, 9'h080, 9'h100: w_code = 3'd7;
      default:                w_code = '0;
    endcase
  end

  assign w_accept = gesture_vld && (r_state == IDLE) && (w_code != '0);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_state_nxt = HOLD;
          w_cnt_nxt   = CNT_W'(1);
        end
      end
      HOLD: begin
        if (r_cnt == HOLD_LIM) begin
          w_state_nxt = COOL;
          w_cnt_nxt   = CNT_W'(1);
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      COOL: begin
        if (r_cnt == COOL_LIM) begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // Next values of the registered outputs; the code is latched only on acceptance.
  always_comb begin
    w_flag_nxt   = '0;
    w_busy_nxt   = (w_state_nxt != IDLE);
    w_reject_nxt = gesture_vld && !w_accept;
    w_rcnt_nxt   = reject_cnt;
    if (w_state_nxt == HOLD) begin
      w_flag_nxt = (r_state == IDLE) ? w_code : flag_beep;
    end
    if (w_reject_nxt && (reject_cnt != RCNT_MAX)) begin
      w_rcnt_nxt = reject_cnt + RCNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      flag_beep  <= '0;
      busy       <= 1'b0;
      reject     <= 1'b0;
      reject_cnt <= '0;
    end else begin
      flag_beep  <= w_flag_nxt;
      busy       <= w_busy_nxt;
      reject     <= w_reject_nxt;
      reject_cnt <= w_rcnt_nxt;
    end
  end

endmodule

// File: tb/tb_gesture_beep_ctrl.sv
// Directed bench for gesture_beep_ctrl with HOLD_CYC=8, COOL_CYC=4.
module tb_gesture_beep_ctrl;

  logic       clk = 1'b0;
  logic       rstn;
  logic [8:0] gesture_data;
  logic       gesture_vld;
  logic [2:0] flag_beep;
  logic       busy;
  logic       reject;
  logic [7:0] reject_cnt;

  int n_cmp = 0;
  int n_err = 0;

  gesture_beep_ctrl #(
    .CLK_FREQ(50_000_000),
    .HOLD_CYC(8),
    .COOL_CYC(4)
  ) dut (
    .clk         (clk),
    .rstn        (rstn),
    .gesture_data(gesture_data),
    .gesture_vld (gesture_vld),
    .flag_beep   (flag_beep),
    .busy        (busy),
    .reject      (reject),
    .reject_cnt  (reject_cnt)
  );

  always #5 clk = ~clk;

  // Advance one rising edge and settle away from it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [2:0] f, input logic b,
                         input logic r, input logic [7:0] rc);
    chk({tag, ".flag"},   32'(flag_beep),  32'(f));
    chk({tag, ".busy"},   32'(busy),       32'(b));
    chk({tag, ".reject"}, 32'(reject),     32'(r));
    chk({tag, ".rcnt"},   32'(reject_cnt), 32'(rc));
  endtask

  // One accepted gesture from IDLE through HOLD and COOL back to IDLE.
  task automatic run_gesture(input logic [8:0] d, input logic [2:0] code, input logic [7:0] rc);
    gesture_vld  = 1'b1;
    gesture_data = d;
    tick();
    gesture_vld  = 1'b0;
    gesture_data = 9'h1FF;
    chk_out("accept", code, 1'b1, 1'b0, rc);
    for (int i = 1; i < 8; i++) begin
      tick();
      chk_out("hold", code, 1'b1, 1'b0, rc);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      chk_out("cool", 3'd0, 1'b1, 1'b0, rc);
    end
    tick();
    chk_out("idle", 3'd0, 1'b0, 1'b0, rc);
  endtask

  logic [8:0] w_d;
  logic [7:0] exp_rc;

  initial begin
    rstn         = 1'b0;
    gesture_vld  = 1'b1;
    gesture_data = 9'h001;

    // Reset held with a valid strobe present must not start a hold.
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_out("rst", 3'd0, 1'b0, 1'b0, 8'd0);
    end
    rstn        = 1'b1;
    gesture_vld = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk_out("post_rst", 3'd0, 1'b0, 1'b0, 8'd0);
    end

    // Single "left" gesture.
    run_gesture(9'h004, 3'd3, 8'd0);

    // Every one-hot input, back to back after each cooldown.
    for (int i = 0; i < 9; i++) begin
      w_d = 9'(1) << i;
      run_gesture(w_d, (i < 6) ? 3'(i + 1) : 3'd7, 8'd0);
    end

    // Invalid reports: none set, then two set, on consecutive cycles.
    gesture_vld  = 1'b1;
    gesture_data = 9'h000;
    tick();
    chk_out("inv_zero", 3'd0, 1'b0, 1'b1, 8'd1);
    gesture_data = 9'h003;
    tick();
    chk_out("inv_multi", 3'd0, 1'b0, 1'b1, 8'd2);
    gesture_vld  = 1'b0;
    tick();
    chk_out("inv_end", 3'd0, 1'b0, 1'b0, 8'd2);

    // Clear the reject count, then strobes during HOLD and COOL are dropped.
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    chk_out("clr", 3'd0, 1'b0, 1'b0, 8'd0);
    gesture_vld  = 1'b1;
    gesture_data = 9'h001;
    tick();
    chk_out("drop_acc", 3'd1, 1'b1, 1'b0, 8'd0);
    for (int e = 1; e <= 12; e++) begin
      gesture_vld  = (e == 3) || (e == 9);
      gesture_data = 9'h002;
      tick();
      chk_out("drop", (e < 8) ? 3'd1 : 3'd0, (e < 12), (e == 3) || (e == 9),
              (e >= 9) ? 8'd2 : ((e >= 3) ? 8'd1 : 8'd0));
    end
    gesture_vld  = 1'b1;
    gesture_data = 9'h002;
    tick();
    chk_out("first_idle", 3'd2, 1'b1, 1'b0, 8'd2);
    gesture_vld = 1'b0;
    for (int i = 0; i < 12; i++) tick();
    chk_out("back_idle", 3'd0, 1'b0, 1'b0, 8'd2);

    // Saturation of the reject counter.
    exp_rc       = 8'd2;
    gesture_vld  = 1'b1;
    gesture_data = 9'h000;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (exp_rc != 8'd255) exp_rc = exp_rc + 8'd1;
      chk("sat.rcnt", 32'(reject_cnt), 32'(exp_rc));
      chk("sat.reject", 32'(reject), 32'd1);
    end
    chk("sat.final", 32'(reject_cnt), 32'd255);

    // Reset in the middle of a hold leaves nothing behind.
    gesture_data = 9'h010;
    tick();
    gesture_vld = 1'b0;
    chk_out("mid_acc", 3'd5, 1'b1, 1'b0, 8'd255);
    tick();
    tick();
    chk_out("mid_hold", 3'd5, 1'b1, 1'b0, 8'd255);
    rstn = 1'b0;
    tick();
    chk_out("mid_rst", 3'd0, 1'b0, 1'b0, 8'd0);
    rstn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_out("after_rst", 3'd0, 1'b0, 1'b0, 8'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
